// File: rtl/cc_row_scanner.sv
// Row-scan controller for a 12-row active-low decoder: request/ack loads row data, then the row is held for DWELL_CYCLES.
// Optional macro CC_ROWSCAN_BLANKING_EN inserts BLANK_CYCLES of blanking after every dwell.
module cc_row_scanner #(
  parameter int DATAWIDTH_SELECTION = 4,
  parameter int ROW_COUNT           = 12,
  parameter int PRESCALER_WIDTH     = 16,
  parameter int DWELL_CYCLES        = 4000,
  parameter int BLANK_CYCLES        = 8
) (
  input  logic                           CC_ROWSCAN_CLOCK_50,
  input  logic                           CC_ROWSCAN_RESET_InHigh,
  input  logic                           CC_ROWSCAN_enable_In,
  input  logic                           CC_ROWSCAN_rowack_In,
  output logic [DATAWIDTH_SELECTION-1:0] CC_ROWSCAN_selection_OutBUS,
  output logic                           CC_ROWSCAN_rowrequest_Out,
  output logic [DATAWIDTH_SELECTION-1:0] CC_ROWSCAN_requestrow_OutBUS,
  output logic                           CC_ROWSCAN_rowstrobe_Out,
  output logic                           CC_ROWSCAN_framedone_Out
);

  localparam int DW = DATAWIDTH_SELECTION;
  localparam int PW = PRESCALER_WIDTH;

  localparam logic [DW-1:0] ROW_FIRST  = DW'(1);
  localparam logic [DW-1:0] ROW_LAST   = DW'(ROW_COUNT);
  localparam logic [PW-1:0] DWELL_LAST = PW'(DWELL_CYCLES - 1);
`ifdef CC_ROWSCAN_BLANKING_EN
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
`endif

  if (ROW_COUNT < 1 || ROW_COUNT > (2 ** DW) - 1) begin : g_bad_row_count
    $error("cc_row_scanner: ROW_COUNT out of range");
  end
  if (DWELL_CYCLES < 2 || DWELL_CYCLES >= (2 ** PW)) begin : g_bad_dwell
    $error("cc_row_scanner: DWELL_CYCLES out of range");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= (2 ** PW)) begin : g_bad_blank
    $error("cc_row_scanner: BLANK_CYCLES out of range");
  end

`ifdef CC_ROWSCAN_BLANKING_EN
  typedef enum logic [1:0] {ST_IDLE, ST_REQUEST, ST_DWELL, ST_BLANK} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_REQUEST, ST_DWELL} state_t;
`endif

  state_t          state_q, state_d;
  logic [DW-1:0]   row_q, row_d;
  logic [PW-1:0]   prescaler_q, prescaler_d;
  logic            wrap;

  logic [DW-1:0]   selection_q, selection_d;
  logic            rowrequest_q, rowrequest_d;
  logic [DW-1:0]   requestrow_q, requestrow_d;
  logic            rowstrobe_q, rowstrobe_d;
  logic            framedone_q, framedone_d;

  always_ff @(posedge CC_ROWSCAN_CLOCK_50) begin
    if (CC_ROWSCAN_RESET_InHigh) begin
      state_q      <= ST_IDLE;
      row_q        <= ROW_FIRST;
      prescaler_q  <= '0;
      selection_q  <= '0;
      rowrequest_q <= 1'b0;
      requestrow_q <= ROW_FIRST;
      rowstrobe_q  <= 1'b0;
      framedone_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      prescaler_q  <= prescaler_d;
      selection_q  <= selection_d;
      rowrequest_q <= rowrequest_d;
      requestrow_q <= requestrow_d;
      rowstrobe_q  <= rowstrobe_d;
      framedone_q  <= framedone_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    prescaler_d = prescaler_q;
    wrap        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        prescaler_d = '0;
        if (CC_ROWSCAN_enable_In) state_d = ST_REQUEST;
      end
      ST_REQUEST: begin
        prescaler_d = '0;
        if (!CC_ROWSCAN_enable_In)     state_d = ST_IDLE;
        else if (CC_ROWSCAN_rowack_In) state_d = ST_DWELL;
      end
      ST_DWELL: begin
        if (!CC_ROWSCAN_enable_In) begin
          state_d     = ST_IDLE;
          prescaler_d = '0;
        end else if (prescaler_q == DWELL_LAST) begin
          // Row advances on the last dwell cycle so requestrow is already correct in the following gap.
          wrap        = (row_q == ROW_LAST);
          row_d       = wrap ? ROW_FIRST : row_q + ROW_FIRST;
          prescaler_d = '0;
`ifdef CC_ROWSCAN_BLANKING_EN
          state_d     = ST_BLANK;
`else
          state_d     = ST_REQUEST;
`endif
        end else begin
          prescaler_d = prescaler_q + 1'b1;
        end
      end
`ifdef CC_ROWSCAN_BLANKING_EN
      ST_BLANK: begin
        if (!CC_ROWSCAN_enable_In) begin
          state_d     = ST_IDLE;
          prescaler_d = '0;
        end else if (prescaler_q == BLANK_LAST) begin
          state_d     = ST_REQUEST;
          prescaler_d = '0;
        end else begin
          prescaler_d = prescaler_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d     = ST_IDLE;
        prescaler_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copy lines up with the state it describes.
  always_comb begin
    selection_d  = (state_d == ST_DWELL) ? row_d : '0;
    rowrequest_d = (state_d == ST_REQUEST);
    requestrow_d = row_d;
    rowstrobe_d  = (state_d == ST_DWELL) && (state_q != ST_DWELL);
    framedone_d  = wrap;
  end

  assign CC_ROWSCAN_selection_OutBUS  = selection_q;
  assign CC_ROWSCAN_rowrequest_Out    = rowrequest_q;
  assign CC_ROWSCAN_requestrow_OutBUS = requestrow_q;
  assign CC_ROWSCAN_rowstrobe_Out     = rowstrobe_q;
  assign CC_ROWSCAN_framedone_Out     = framedone_q;

endmodule
